// File: rtl/pipeline_buf.sv
// -----------------------------------------------------------------------------
// pipeline_buf
//
// Elastic in-order pipeline stage with DEPTH entries. It sits between two CPU
// pipeline stages that use the valid/allow handshake, and it absorbs downstream
// back-pressure without inserting bubbles. It supports stall (freeze) and
// flush (discard everything, including the current input).
//
// Optional feature, selected by the macro PIPELINE_BUF_BYPASS_EN:
//   When this macro is defined and the buffer is empty, a payload that is
//   offered while the downstream stage accepts passes straight through in the
//   same cycle. Nothing is written and count stays 0.
//   When it is undefined, valid_out depends only on stored entries. The
//   minimum in->out latency is then 1 cycle, and there is no combinational
//   path from in to out.
//
// Parameters
//   WIDTH        payload width in bits
//   DEPTH        number of entries (>=1, any integer)
//   RESET        1: the head slot is loaded with RESET_VALUE on reset
//   RESET_VALUE  value presented on out after reset when RESET=1
//
// Ports
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous active-high reset, dominates everything
//   stall      in   freeze: no push, no pop, valid_out=0, allow_in=0
//   flush      in   empty the buffer and drop the current input
//   valid_in   in   upstream offers a payload
//   allow_in   out  this stage accepts a payload this cycle (comb)
//   allow_out  in   downstream accepts a payload this cycle
//   valid_out  out  head payload is presented downstream
//   in         in   upstream payload
//   out        out  head payload
//   count      out  number of entries held (registered)
// -----------------------------------------------------------------------------
module pipeline_buf #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 2,
    parameter bit               RESET       = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       valid_in,
    output logic                       allow_in,
    input  logic                       allow_out,
    output logic                       valid_out,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    // A single-entry buffer still needs a 1-bit pointer to index storage.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;

    logic not_empty_s;
    logic has_room_s;
    logic bypass_s;
    logic push_s;
    logic pop_s;

    // Pointers wrap by explicit compare, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return PTR_ZERO;
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    // Handshake decode: allow_in, valid_out, head data and push/pop qualifiers.
    always_comb begin
        not_empty_s = (count_r != CNT_ZERO);
        has_room_s  = (count_r < DEPTH_C);
        // A full buffer still accepts when the head leaves in the same cycle.
        allow_in    = flush | (~stall & (has_room_s | allow_out));
`ifdef PIPELINE_BUF_BYPASS_EN
        bypass_s    = ~not_empty_s & ~stall & ~flush & valid_in & allow_out;
`else
        bypass_s    = 1'b0;
`endif
        valid_out   = (not_empty_s & ~stall) | bypass_s;
        if (bypass_s) begin
            out = in;
        end else begin
            out = mem_r[rd_ptr_r];
        end
        // A bypassed payload is consumed downstream directly and never stored.
        push_s = valid_in & allow_in & ~flush & ~bypass_s;
        // Pop only counts stored entries, so a bypass never pops.
        pop_s  = not_empty_s & ~stall & allow_out & ~flush;
    end

    // Pointer and occupancy state; reset dominates flush, and flush dominates stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage. Only the head slot has a reset value, and only when RESET is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (RESET) begin
                mem_r[PTR_ZERO] <= RESET_VALUE;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= in;
        end
    end

    assign count = count_r;

    // Occupancy must never exceed DEPTH after a push without a matching pop.
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        (push_s && !pop_s) |-> (count_r < DEPTH_C));

    // A pop must never be taken from an empty buffer.
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        pop_s |-> (count_r != CNT_ZERO));

    // Occupancy must always stay within 0..DEPTH.
    a_count_range : assert property (@(posedge clk) disable iff (reset)
        count_r <= DEPTH_C);

endmodule
